// File: rtl/axi_mem_slave.sv
// AXI4 memory-mapped responder backed by an internal array of 64-bit words.
// Serves INCR bursts of 8-byte beats and answers bad beats with SLVERR.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   S_AXI_AW*        write address channel (ADDR, ID, LEN, SIZE, BURST)
//   S_AXI_W*         write data channel (DATA, STRB, LAST)
//   S_AXI_B*         write response channel (ID, RESP)
//   S_AXI_AR*        read address channel (ADDR, ID, LEN, SIZE, BURST)
//   S_AXI_R*         read data channel (DATA, ID, RESP, LAST)
//
// Optional build macro AXI_MEM_LAT_EN adds RESP_LATENCY wait cycles
// before the first RVALID of a read and before BVALID of a write.
// The read and write engines run independently of each other.
// Memory contents survive reset; only the engines are cleared.
module axi_mem_slave #(
   parameter int                          AXI_ADDR_WIDTH = 32,
   parameter int                          AXI_DATA_WIDTH = 64,
   parameter int                          AXI_ID_WIDTH   = 4,
   parameter int                          MEM_DEPTH      = 1024,
   parameter logic [AXI_ADDR_WIDTH-1:0]   MEM_BASE       = '0,
   parameter int                          RESP_LATENCY   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [AXI_ID_WIDTH-1:0]       S_AXI_AWID,
   input  logic [7:0]                    S_AXI_AWLEN,
   input  logic [2:0]                    S_AXI_AWSIZE,
   input  logic [1:0]                    S_AXI_AWBURST,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                          S_AXI_WLAST,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [AXI_ID_WIDTH-1:0]       S_AXI_BID,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [AXI_ID_WIDTH-1:0]       S_AXI_ARID,
   input  logic [7:0]                    S_AXI_ARLEN,
   input  logic [2:0]                    S_AXI_ARSIZE,
   input  logic [1:0]                    S_AXI_ARBURST,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [AXI_ID_WIDTH-1:0]       S_AXI_RID,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RLAST,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY
);

   localparam int AW    = AXI_ADDR_WIDTH;
   localparam int DW    = AXI_DATA_WIDTH;
   localparam int IW    = AXI_ID_WIDTH;
   localparam int SW    = AXI_DATA_WIDTH / 8;
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [AW-1:0] DEPTH_A     = AW'(MEM_DEPTH);
   localparam logic [AW-1:0] BEAT_BYTES  = AW'(8);
   localparam logic [1:0]    RESP_OKAY   = 2'b00;
   localparam logic [1:0]    RESP_SLVERR = 2'b10;
   localparam logic [1:0]    BURST_INCR  = 2'b01;
   localparam logic [2:0]    SIZE_8B     = 3'd3;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_WAIT,
      W_RESP
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_DATA,
      R_WAIT
   } r_state_e;

   // Borrow out of the subtraction means the address is below MEM_BASE.
   function automatic logic in_range(input logic [AW-1:0] a);
      logic [AW:0] diff;
      diff = {1'b0, a} - {1'b0, MEM_BASE};
      return !diff[AW] && ((diff[AW-1:0] >> 3) < DEPTH_A);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a - MEM_BASE;
      return IDX_W'(off >> 3);
   endfunction

   logic [DW-1:0] mem_q [MEM_DEPTH];

`ifdef AXI_MEM_LAT_EN
   localparam int LAT_W = (RESP_LATENCY > 0) ? $clog2(RESP_LATENCY + 1) : 1;
   logic [LAT_W-1:0] w_lat_q, w_lat_d;
   logic [LAT_W-1:0] r_lat_q, r_lat_d;
`else
   logic [31:0] unused_lat;
   assign unused_lat = 32'(RESP_LATENCY);
`endif

   // ---------------- write engine ----------------
   w_state_e          w_state_q, w_state_d;
   logic [IW-1:0]     w_id_q, w_id_d;
   logic [AW-1:0]     w_addr_q, w_addr_d;
   logic [7:0]        w_len_q, w_len_d;
   logic [7:0]        w_cnt_q, w_cnt_d;
   logic              w_berr_q, w_berr_d;
   logic              w_err_q, w_err_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [IW-1:0]     bid_q, bid_d;
   logic [1:0]        bresp_q, bresp_d;

   logic              w_last;
   logic              w_inr;
   logic              w_beat_err;
   logic              aw_err;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_widx;

   assign w_last     = (w_cnt_q == w_len_q);
   assign w_inr      = in_range(w_addr_q);
   assign w_beat_err = !w_inr || (S_AXI_WLAST != w_last);
   assign aw_err     = (S_AXI_AWSIZE != SIZE_8B) ||
                       (S_AXI_AWBURST != BURST_INCR);
   assign mem_widx   = word_idx(w_addr_q);

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_berr_d  = w_berr_q;
      w_err_d   = w_err_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
`ifdef AXI_MEM_LAT_EN
      w_lat_d   = w_lat_q;
`endif
      unique case (w_state_q)
         W_IDLE: begin
            if (S_AXI_AWVALID && awready_q) begin
               w_id_d    = S_AXI_AWID;
               w_addr_d  = S_AXI_AWADDR;
               w_len_d   = S_AXI_AWLEN;
               w_cnt_d   = 8'd0;
               w_berr_d  = aw_err;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (S_AXI_WVALID && wready_q) begin
               // Erroneous bursts still consume beats, but never touch memory.
               mem_we = w_inr && !w_berr_q && !rst;
               if (w_beat_err) begin
                  w_err_d = 1'b1;
               end
               // The beat counter, not WLAST, decides where the burst ends.
               if (w_last) begin
                  bid_d   = w_id_q;
                  bresp_d = (w_err_d || w_berr_q) ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_MEM_LAT_EN
                  if (RESP_LATENCY == 0) begin
                     w_state_d = W_RESP;
                  end else begin
                     w_state_d = W_WAIT;
                     w_lat_d   = LAT_W'(RESP_LATENCY - 1);
                  end
`else
                  w_state_d = W_RESP;
`endif
               end else begin
                  w_cnt_d  = w_cnt_q + 8'd1;
                  w_addr_d = w_addr_q + BEAT_BYTES;
               end
            end
         end
`ifdef AXI_MEM_LAT_EN
         W_WAIT: begin
            if (w_lat_q == '0) begin
               w_state_d = W_RESP;
            end else begin
               w_lat_d = w_lat_q - LAT_W'(1);
            end
         end
`endif
         W_RESP: begin
            if (S_AXI_BREADY && bvalid_q) begin
               w_state_d = W_IDLE;
               bresp_d   = RESP_OKAY;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   // ---------------- read engine ----------------
   r_state_e          r_state_q, r_state_d;
   logic [IW-1:0]     r_id_q, r_id_d;
   logic [AW-1:0]     r_addr_q, r_addr_d;
   logic [7:0]        r_len_q, r_len_d;
   logic [7:0]        r_cnt_q, r_cnt_d;
   logic              r_berr_q, r_berr_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [IW-1:0]     rid_q, rid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rlast_q, rlast_d;

   logic              r_last;
   logic              ar_err;
   logic              ld_en;
   logic [AW-1:0]     ld_addr;
   logic              ld_berr;

   assign r_last = (r_cnt_q == r_len_q);
   assign ar_err = (S_AXI_ARSIZE != SIZE_8B) ||
                   (S_AXI_ARBURST != BURST_INCR);

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_berr_d  = r_berr_q;
      rdata_d   = rdata_q;
      rid_d     = rid_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      ld_en     = 1'b0;
      ld_addr   = r_addr_q;
      ld_berr   = r_berr_q;
`ifdef AXI_MEM_LAT_EN
      r_lat_d   = r_lat_q;
`endif
      unique case (r_state_q)
         R_IDLE: begin
            if (S_AXI_ARVALID && arready_q) begin
               r_id_d   = S_AXI_ARID;
               r_addr_d = S_AXI_ARADDR;
               r_len_d  = S_AXI_ARLEN;
               r_cnt_d  = 8'd0;
               r_berr_d = ar_err;
               rid_d    = S_AXI_ARID;
               rlast_d  = (S_AXI_ARLEN == 8'd0);
               ld_en    = 1'b1;
               ld_addr  = S_AXI_ARADDR;
               ld_berr  = ar_err;
`ifdef AXI_MEM_LAT_EN
               if (RESP_LATENCY == 0) begin
                  r_state_d = R_DATA;
               end else begin
                  r_state_d = R_WAIT;
                  r_lat_d   = LAT_W'(RESP_LATENCY - 1);
               end
`else
               r_state_d = R_DATA;
`endif
            end
         end
`ifdef AXI_MEM_LAT_EN
         R_WAIT: begin
            if (r_lat_q == '0) begin
               r_state_d = R_DATA;
            end else begin
               r_lat_d = r_lat_q - LAT_W'(1);
            end
         end
`endif
         R_DATA: begin
            if (S_AXI_RREADY && rvalid_q) begin
               if (r_last) begin
                  r_state_d = R_IDLE;
               end else begin
                  // Prefetch the next beat so RVALID stays high with no bubble.
                  r_cnt_d  = r_cnt_q + 8'd1;
                  r_addr_d = r_addr_q + BEAT_BYTES;
                  rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                  ld_en    = 1'b1;
                  ld_addr  = r_addr_q + BEAT_BYTES;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      // mem_q is read before this edge's write lands: old data wins.
      if (ld_en) begin
         if (!ld_berr && in_range(ld_addr)) begin
            rdata_d = mem_q[word_idx(ld_addr)];
            rresp_d = RESP_OKAY;
         end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end
      end
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_berr_q  <= 1'b0;
         w_err_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_berr_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rid_q     <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
`ifdef AXI_MEM_LAT_EN
         w_lat_q   <= '0;
         r_lat_q   <= '0;
`endif
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_berr_q  <= w_berr_d;
         w_err_q   <= w_err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_berr_q  <= r_berr_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rid_q     <= rid_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
`ifdef AXI_MEM_LAT_EN
         w_lat_q   <= w_lat_d;
         r_lat_q   <= r_lat_d;
`endif
      end
   end

   // Storage has no reset so contents survive an engine reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < SW; b++) begin
            if (S_AXI_WSTRB[b]) begin
               mem_q[mem_widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
         end
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BID     = bid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RID     = rid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave with a word model and
// queues of expected B and R responses.
module tb_axi_mem_slave;

   localparam int          AW    = 32;
   localparam int          DW    = 64;
   localparam int          IW    = 4;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic          clk;
   logic          rst;
   logic [AW-1:0] awaddr;
   logic [IW-1:0] awid;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          awvalid;
   logic          awready;
   logic [DW-1:0] wdata;
   logic [7:0]    wstrb;
   logic          wlast;
   logic          wvalid;
   logic          wready;
   logic [IW-1:0] bid;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [AW-1:0] araddr;
   logic [IW-1:0] arid;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready;
   logic [DW-1:0] rdata;
   logic [IW-1:0] rid;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;

   axi_mem_slave #(
      .AXI_ADDR_WIDTH (AW),
      .AXI_DATA_WIDTH (DW),
      .AXI_ID_WIDTH   (IW),
      .MEM_DEPTH      (DEPTH),
      .MEM_BASE       (BASE),
      .RESP_LATENCY   (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWID    (awid),
      .S_AXI_AWLEN   (awlen),
      .S_AXI_AWSIZE  (awsize),
      .S_AXI_AWBURST (awburst),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WLAST   (wlast),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BID     (bid),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARID    (arid),
      .S_AXI_ARLEN   (arlen),
      .S_AXI_ARSIZE  (arsize),
      .S_AXI_ARBURST (arburst),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RID     (rid),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RLAST   (rlast),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] id;
      logic [1:0]    resp;
   } bexp_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [IW-1:0] id;
      logic [1:0]    resp;
      logic          last;
   } rexp_t;

   bexp_t         bq[$];
   rexp_t         rq[$];
   logic [63:0]   mdl [int];
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit tb_inr(input logic [31:0] a);
      longint d;
      d = longint'(a) - longint'(BASE);
      return (d >= 0) && ((d / 8) < DEPTH);
   endfunction

   function automatic int tb_idx(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 8);
   endfunction

   task automatic axi_wr(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [63:0] base,
                         input logic [7:0] strb, input logic [2:0] size,
                         input logic [1:0] burst, input bit bad_last);
      bit          berr;
      logic [1:0]  er;
      logic [31:0] a;
      logic [63:0] w;
      bexp_t       e;
      int          n;
      berr = (size != 3'd3) || (burst != 2'b01);
      er   = (berr || bad_last) ? 2'b10 : 2'b00;
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 32'(8 * i);
         if (!tb_inr(a)) begin
            er = 2'b10;
         end else if (!berr) begin
            w = mdl.exists(tb_idx(a)) ? mdl[tb_idx(a)] : 64'h0;
            for (int b = 0; b < 8; b++)
               if (strb[b]) w[8*b +: 8] = (base + 64'(i)) >> (8 * b);
            mdl[tb_idx(a)] = w;
         end
      end
      bq.push_back('{id: id, resp: er});
      awaddr = addr; awid = id; awlen = len;
      awsize = size; awburst = burst; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      chk("aw_ready", 64'(awready), 64'd1);
      @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wdata  = base + 64'(i);
         wstrb  = strb;
         wlast  = bad_last ? (i == 0) : (i == int'(len));
         wvalid = 1'b1;
         n = 0;
         while (!wready && n < 50) begin @(negedge clk); n++; end
         chk("w_ready", 64'(wready), 64'd1);
         @(negedge clk);
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      chk("b_latency", 64'(bvalid), 64'd1);
      @(negedge clk);
      chk("b_hold", 64'(bvalid), 64'd1);
      e = bq.pop_front();
      chk("bid", 64'(bid), 64'(e.id));
      chk("bresp", 64'(bresp), 64'(e.resp));
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("b_drop", 64'(bvalid), 64'd0);
   endtask

   task automatic axi_rd(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int stall,
                         input int abort_beat);
      bit          berr;
      logic [31:0] a;
      rexp_t       e;
      int          n;
      berr = (size != 3'd3) || (burst != 2'b01);
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 32'(8 * i);
         e.id   = id;
         e.last = (i == int'(len));
         if (!berr && tb_inr(a)) begin
            e.data = mdl[tb_idx(a)];
            e.resp = 2'b00;
         end else begin
            e.data = 64'h0;
            e.resp = 2'b10;
         end
         rq.push_back(e);
      end
      araddr = addr; arid = id; arlen = len;
      arsize = size; arburst = burst; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin @(negedge clk); n++; end
      chk("ar_ready", 64'(arready), 64'd1);
      @(negedge clk);
      arvalid = 1'b0;
      chk("r_latency", 64'(rvalid), 64'd1);
      for (int i = 0; i <= int'(len); i++) begin
         if (i == abort_beat) begin
            chk("r_abort_valid", 64'(rvalid), 64'd1);
            return;
         end
         if (i > 0) chk("r_b2b", 64'(rvalid), 64'd1);
         n = 0;
         while (!rvalid && n < 50) begin @(negedge clk); n++; end
         e = rq.pop_front();
         for (int s = 0; s < stall; s++) begin
            chk("r_hold_data", rdata, e.data);
            chk("r_hold_last", 64'(rlast), 64'(e.last));
            @(negedge clk);
         end
         chk("rvalid", 64'(rvalid), 64'd1);
         chk("rdata", rdata, e.data);
         chk("rresp", 64'(rresp), 64'(e.resp));
         chk("rlast", 64'(rlast), 64'(e.last));
         chk("rid", 64'(rid), 64'(e.id));
         rready = 1'b1;
         @(negedge clk);
         rready = 1'b0;
      end
      chk("r_done", 64'(rvalid), 64'd0);
      chk("ar_return", 64'(arready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      awaddr = '0; awid = '0; awlen = '0; awsize = 3'd3;
      awburst = 2'b01; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0;
      araddr = '0; arid = '0; arlen = '0; arsize = 3'd3;
      arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_wready", 64'(wready), 64'd0);
      chk("rst_bvalid", 64'(bvalid), 64'd0);
      chk("rst_arready", 64'(arready), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_rid", 64'(rid), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_awready", 64'(awready), 64'd1);
      chk("idle_arready", 64'(arready), 64'd1);

      // single write, then read it back
      axi_wr(32'h10, 4'd3, 8'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF,
             3'd3, 2'b01, 1'b0);
      axi_rd(32'h10, 4'd3, 8'd0, 3'd3, 2'b01, 0, 99);

      // strobed write over a full word
      axi_wr(32'h18, 4'd1, 8'd0, 64'h1111_1111_1111_1111, 8'hFF,
             3'd3, 2'b01, 1'b0);
      axi_wr(32'h18, 4'd2, 8'd0, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F,
             3'd3, 2'b01, 1'b0);
      axi_rd(32'h18, 4'd2, 8'd0, 3'd3, 2'b01, 0, 99);

      // burst read of words 0..3 with a stalling master
      axi_wr(32'h0, 4'd4, 8'd3, 64'd0, 8'hFF, 3'd3, 2'b01, 1'b0);
      axi_rd(32'h0, 4'd5, 8'd3, 3'd3, 2'b01, 2, 99);

      // last word, then run off the end of memory
      axi_wr(32'h1FF8, 4'd6, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF,
             3'd3, 2'b01, 1'b0);
      axi_rd(32'h1FF8, 4'd7, 8'd1, 3'd3, 2'b01, 0, 99);
      axi_wr(32'h1FF8, 4'd8, 8'd1, 64'h7777_0000_0000_0000, 8'hFF,
             3'd3, 2'b01, 1'b0);
      axi_rd(32'h1FF8, 4'd8, 8'd0, 3'd3, 2'b01, 0, 99);

      // WLAST on the wrong beat
      axi_wr(32'h40, 4'd9, 8'd1, 64'h5555_0000_0000_0000, 8'hFF,
             3'd3, 2'b01, 1'b1);
      axi_rd(32'h40, 4'd9, 8'd1, 3'd3, 2'b01, 0, 99);

      // unsupported size / burst type
      axi_wr(32'h18, 4'd10, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF,
             3'd2, 2'b01, 1'b0);
      axi_rd(32'h18, 4'd10, 8'd1, 3'd3, 2'b00, 0, 99);
      axi_rd(32'h18, 4'd11, 8'd0, 3'd3, 2'b01, 0, 99);

      // reset in the middle of a long read
      axi_wr(32'h0, 4'd11, 8'd7, 64'h100, 8'hFF, 3'd3, 2'b01, 1'b0);
      axi_rd(32'h0, 4'd12, 8'd7, 3'd3, 2'b01, 0, 2);
      rq.delete();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
      chk("mid_rst_rdata", rdata, 64'd0);
      chk("mid_rst_arready", 64'(arready), 64'd0);
      rst = 1'b0;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      chk("post_rst_arready", 64'(arready), 64'd1);
      axi_rd(32'h0, 4'd13, 8'd7, 3'd3, 2'b01, 0, 99);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 memory-mapped responder (slave) backed by an internal word array; the target end for the single-beat and burst AXI master drivers in the cache subsystem.
- Independent write engine (AW/W/B) and read engine (AR/R), which may run concurrently.
- INCR bursts of 8-byte beats, per-byte write strobes, ID echo, and SLVERR for out-of-range or unsupported accesses.
- Serves as the backing memory model and on-chip scratch memory behind the cache.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width; fixed 8-byte beats.
- AXI_ID_WIDTH, 4, ID width.
- MEM_DEPTH, 1024, number of 64-bit words.
- MEM_BASE, 32'h0000_0000, byte address of word 0.
- RESP_LATENCY, 4, extra wait cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- S_AXI_AWADDR  in  AXI_ADDR_WIDTH  write address
- S_AXI_AWID  in  AXI_ID_WIDTH  write ID
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWSIZE  in  3  beat size
- S_AXI_AWBURST  in  2  burst type
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  AXI_DATA_WIDTH / S_AXI_WSTRB  in  AXI_DATA_WIDTH/8 / S_AXI_WLAST  in  1
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BID  out  AXI_ID_WIDTH / S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  AXI_ADDR_WIDTH / S_AXI_ARID  in  AXI_ID_WIDTH / S_AXI_ARLEN  in  8 / S_AXI_ARSIZE  in  3 / S_AXI_ARBURST  in  2
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  AXI_DATA_WIDTH / S_AXI_RID  out  AXI_ID_WIDTH / S_AXI_RRESP  out  2 / S_AXI_RLAST  out  1 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - All READY/VALID outputs, BRESP/RRESP, RLAST, BID/RID and RDATA are 0; both FSMs go to idle.
  - Memory contents are retained; in-flight transactions are discarded silently.
- Address decode:
  - idx = (addr - MEM_BASE) >> 3; addr[2:0] is ignored (aligned down).
  - A beat is in range iff addr >= MEM_BASE and idx < MEM_DEPTH; range is checked per beat.
  - Address increments by 8 per beat; 4 KB crossing is not checked.
- Burst type: a burst is erroneous if AxSIZE != 3'd3 or AxBURST != INCR (2'b01). It completes normally on the handshake side but with no memory effect.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID/addr/len/error, beat count=0, go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write bytes with WSTRB[i]=1 if the beat is in range and the burst is not erroneous, then advance.
    - The burst ends at the beat where count==len, regardless of WLAST. Go to W_RESP.
    - Any beat where WLAST != (count==len) flags an error.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=2'b10 if any error or any out-of-range beat, else 2'b00.
    - BVALID/BID/BRESP are held until BREADY; then go to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, latch ID/addr/len/error, load the RDATA register, go to R_DATA.
  - R_DATA: RVALID=1 starting the cycle after the AR handshake (1-cycle latency).
    - RID=latched ID; RLAST=(count==len).
    - RRESP=2'b10 with RDATA=0 for an out-of-range beat or an erroneous burst; otherwise 2'b00.
    - RDATA/RRESP/RLAST are stable while RVALID && !RREADY.
    - On a handshake, load the next beat into the RDATA register (back-to-back beats, no bubble). After the last handshake, go to R_IDLE; ARREADY returns the following cycle.
- Read-during-write to the same word in the same cycle: the read register captures the old value.
- One outstanding transaction per direction; no reordering.

Optional Feature:
- AXI_MEM_LAT_EN.
  - Defined: a RESP_LATENCY-cycle counter is inserted before the first RVALID of each read burst, and before BVALID after the last W beat. During the count, VALID=0 and the FSMs sit in R_WAIT / W_WAIT.
  - Undefined: latencies are exactly as above; the RESP_LATENCY parameter is unused.

Test Plan:
- Single write: AW addr=0x10, len=0, ID=3; W data=0xDEADBEEF_CAFEF00D, strb=0xFF, WLAST=1 -> BVALID the cycle after the W handshake, BID=3, BRESP=0; word 2 holds the data.
- Strobed write: write 0x1111_1111_1111_1111 to 0x18, then strb=0x0F data=0xAAAA_AAAA_BBBB_BBBB -> read 0x18 returns 0x1111_1111_BBBB_BBBB, RRESP=0.
- Burst read: preload words 0..3 = 0..3; AR addr=0, len=3, ID=5, RREADY stuck low 2 cycles per beat -> RDATA 0,1,2,3 held stable, RID=5, RLAST only on beat 3.
- Range error: AR addr=MEM_BASE+8*MEM_DEPTH-8, len=1 -> beat0 RRESP=0 with valid data; beat1 RRESP=2'b10, RDATA=0, RLAST=1.
- WLAST mismatch: AWLEN=1 with WLAST=1 on beat 0 -> two beats accepted, BRESP=2'b10.
- Reset mid-burst: assert rst during beat 2 of a len=7 read -> next cycle RVALID=0, ARREADY=1 after rst deasserts, memory unchanged.
